mux4x1_gate: RTL and testbench
==============================

Name: mux4x1_gate

Overview:
- Gate-level 4:1 multiplexer, WIDTH bits wide.
- Combinational output y follows the inputs with zero clock latency; this is the primary datapath.
- A registered copy of the output, the registered select code and a select-change pulse are provided for synchronous consumers.
- Leaf cell in the combinational/datapath library, instantiated wherever a structural (primitive-built) mux is required.

Parameters:
- WIDTH, 1, bit width of each data input and of y / y_q (legal range 1..64).

Ports:
- clk_i  input  1  clock; all flops rising-edge triggered.
- rst_ni  input  1  asynchronous reset, active-low.
- x0  input  WIDTH  data input, selected by code 0.
- x1  input  WIDTH  data input, selected by code 1.
- x2  input  WIDTH  data input, selected by code 2.
- x3  input  WIDTH  data input, selected by code 3.
- s0  input  1  select MSB.
- s1  input  1  select LSB.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  y registered on clk_i.
- sel_q  output  2  registered select code {s0,s1}.
- sel_chg_o  output  1  one-cycle pulse when the select code changed since the previous clock edge.

Behaviour:
- Select code is sel = {s0,s1}, with s0 as MSB. Mapping:
  - s0=0 s1=0 -> y=x0
  - s0=0 s1=1 -> y=x1
  - s0=1 s1=0 -> y=x2
  - s0=1 s1=1 -> y=x3
- y is purely combinational and independent of clk_i and rst_ni; it is valid with no clock running.
- Structure: per bit, y[i] = (~s0 & ~s1 & x0[i]) | (~s0 & s1 & x1[i]) | (s0 & ~s1 & x2[i]) | (s0 & s1 & x3[i]).
  - Build from explicit not/and/or gate primitives: two inverters shared across bits, four 3-input ANDs and one 4-input OR per bit, generated over WIDTH.
  - No conditional operator, case or if in the y path.
- X/Z on a select line: y follows gate-primitive X propagation; no special handling.
- Registers, on each rising clk_i edge with rst_ni=1:
  - y_q <= y
  - sel_q <= {s0,s1}
  - sel_chg_o <= ({s0,s1} != sel_q)
- Latency: y is 0 cycles; y_q, sel_q and sel_chg_o are 1 cycle.
- Reset: rst_ni=0 immediately (asynchronously) forces y_q=0, sel_q=2'b00, sel_chg_o=0, and holds them while low. y is unaffected by reset.
- Reset mid-operation: registers clear without waiting for a clock edge.
- First edge after reset release: compares against sel_q=00, so a select of 00 gives sel_chg_o=0, and any other select gives sel_chg_o=1.
- Select held constant: sel_chg_o=0 from the second edge onward.
- A select change and a data change in the same cycle are both captured at the next edge; y_q reflects the new selection.

Optional Feature:
- Macro: MUX4X1_GATE_PARITY_EN.
- Defined:
  - Adds output par_q (1 bit) = XOR-reduction of y, registered on clk_i, reset to 0.
  - Adds output par_o (1 bit) = combinational XOR-reduction of y, built from xor primitives.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- WIDTH=1, all inputs 0, each of the four select codes -> y=0 for every code.
- One-hot data with the matching select, checked after 20 ns settle and without toggling the clock:
  - x0=1, s0=0 s1=0 -> y=1
  - x1=1, s0=0 s1=1 -> y=1
  - x2=1, s0=1 s1=0 -> y=1
  - x3=1, s0=1 s1=1 -> y=1
- Isolation: x0=x1=x2=1, x3=0, s0=1 s1=1 -> y=0. Then x3=1 with the others 0, s0=0 s1=0 -> y=0.
- WIDTH=8, x0=8'h11, x1=8'h22, x2=8'h44, x3=8'h88, sweep codes 0..3 -> y=11,22,44,88. y_q shows the same sequence one clock later.
- Select change: hold sel=01 for 3 clocks, then switch to 10 -> sel_chg_o=1 for exactly one cycle after the switch, and sel_q=2'b10.
- Assert rst_ni=0 between clock edges while y_q=8'h88 -> y_q=0, sel_q=00, sel_chg_o=0 immediately, while y still equals the selected input.
  - With MUX4X1_GATE_PARITY_EN defined and y=8'h07: par_o=1, and par_q=1 after one clock.

Source files
------------

// File: rtl/mux4x1_gate.sv
// Structural 4:1 mux, WIDTH bits, built from gate primitives, with registered copies.
// Define MUX4X1_GATE_PARITY_EN to add the parity outputs par_o and par_q.
module mux4x1_gate #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [1:0]       sel_q,
  output logic             sel_chg_o
`ifdef MUX4X1_GATE_PARITY_EN
  ,
  output logic             par_o,
  output logic             par_q
`endif
);

  wire s0_n;
  wire s1_n;

  // Select inverters are shared by every bit slice.
  not u_inv_s0 (s0_n, s0);
  not u_inv_s1 (s1_n, s1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wire t0, t1, t2, t3;
    and u_and0 (t0, s0_n, s1_n, x0[i]);
    and u_and1 (t1, s0_n, s1,   x1[i]);
    and u_and2 (t2, s0,   s1_n, x2[i]);
    and u_and3 (t3, s0,   s1,   x3[i]);
    or  u_or   (y[i], t0, t1, t2, t3);
  end

  logic [1:0] sel_d;
  logic       sel_chg_d;
  logic       sel_chg_q;

  always_comb begin
    sel_d     = {s0, s1};
    sel_chg_d = (sel_d != sel_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q       <= '0;
      sel_q     <= 2'b00;
      sel_chg_q <= 1'b0;
    end else begin
      y_q       <= y;
      sel_q     <= sel_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign sel_chg_o = sel_chg_q;

`ifdef MUX4X1_GATE_PARITY_EN
  wire [WIDTH-1:0] par_chain;

  // Linear xor chain; the last tap is the reduction of y.
  assign par_chain[0] = y[0];
  for (genvar i = 1; i < WIDTH; i++) begin : g_par
    xor u_xor (par_chain[i], par_chain[i-1], y[i]);
  end

  assign par_o = par_chain[WIDTH-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_o;
    end
  end
`endif

endmodule

// File: tb/tb_mux4x1_gate.sv
// Self-checking bench for mux4x1_gate: WIDTH=1 and WIDTH=8 instances, vector table
// for the combinational path plus directed sequences for the registered outputs.
module tb_mux4x1_gate;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] x0, x1, x2, x3;
  logic       s0, s1;

  logic [7:0] y8, y8_q;
  logic [1:0] sel8_q;
  logic       chg8;
  logic       y1, y1_q;
  logic [1:0] sel1_q;
  logic       chg1;
`ifdef MUX4X1_GATE_PARITY_EN
  logic       par8_o, par8_q, par1_o, par1_q;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mux4x1_gate #(.WIDTH(8)) u_dut8 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .s0        (s0),
    .s1        (s1),
    .y         (y8),
    .y_q       (y8_q),
    .sel_q     (sel8_q),
    .sel_chg_o (chg8)
`ifdef MUX4X1_GATE_PARITY_EN
    ,
    .par_o     (par8_o),
    .par_q     (par8_q)
`endif
  );

  mux4x1_gate #(.WIDTH(1)) u_dut1 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .x0        (x0[0]),
    .x1        (x1[0]),
    .x2        (x2[0]),
    .x3        (x3[0]),
    .s0        (s0),
    .s1        (s1),
    .y         (y1),
    .y_q       (y1_q),
    .sel_q     (sel1_q),
    .sel_chg_o (chg1)
`ifdef MUX4X1_GATE_PARITY_EN
    ,
    .par_o     (par1_o),
    .par_q     (par1_q)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] x0, x1, x2, x3;
    logic       s0, s1;
    logic [7:0] y_exp;
  } vec_t;

  vec_t vecs[14];
  logic [7:0] sweep_exp[4];

  initial begin
    vecs[0]  = '{"zero_c0",  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{"zero_c1",  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{"zero_c2",  8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{"zero_c3",  8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[4]  = '{"hot_x0",   8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01};
    vecs[5]  = '{"hot_x1",   8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01};
    vecs[6]  = '{"hot_x2",   8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 8'h01};
    vecs[7]  = '{"hot_x3",   8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1, 8'h01};
    vecs[8]  = '{"iso_x3",   8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[9]  = '{"iso_x0",   8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{"sweep_c0", 8'h11, 8'h22, 8'h44, 8'h88, 1'b0, 1'b0, 8'h11};
    vecs[11] = '{"sweep_c1", 8'h11, 8'h22, 8'h44, 8'h88, 1'b0, 1'b1, 8'h22};
    vecs[12] = '{"sweep_c2", 8'h11, 8'h22, 8'h44, 8'h88, 1'b1, 1'b0, 8'h44};
    vecs[13] = '{"sweep_c3", 8'h11, 8'h22, 8'h44, 8'h88, 1'b1, 1'b1, 8'h88};
    sweep_exp[0] = 8'h11;
    sweep_exp[1] = 8'h22;
    sweep_exp[2] = 8'h44;
    sweep_exp[3] = 8'h88;

    rst_ni = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    s0 = 1'b0; s1 = 1'b0;
    #12;
    check("rst_y_q",      y8_q,   8'h00);
    check("rst_sel_q",    sel8_q, 2'b00);
    check("rst_sel_chg",  chg8,   1'b0);
    check("rst_y1_q",     y1_q,   1'b0);

    // Combinational path exercised while registers are held in reset.
    for (int i = 0; i < 14; i++) begin
      x0 = vecs[i].x0; x1 = vecs[i].x1; x2 = vecs[i].x2; x3 = vecs[i].x3;
      s0 = vecs[i].s0; s1 = vecs[i].s1;
      #20;
      check({vecs[i].name, "_y8"}, y8, vecs[i].y_exp);
      check({vecs[i].name, "_y1"}, y1, vecs[i].y_exp[0]);
      check({vecs[i].name, "_yq_rst"}, y8_q, 8'h00);
    end

    // Registered sweep.
    @(negedge clk_i);
    x0 = 8'h11; x1 = 8'h22; x2 = 8'h44; x3 = 8'h88;
    s0 = 1'b0; s1 = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("first_edge_y_q",     y8_q,   8'h11);
    check("first_edge_sel_q",   sel8_q, 2'b00);
    check("first_edge_sel_chg", chg8,   1'b0);
    for (int c = 1; c < 4; c++) begin
      s0 = c[1]; s1 = c[0];
      #1;
      check("sweep_y_comb", y8, sweep_exp[c]);
      check("sweep_y_q_lag", y8_q, sweep_exp[c-1]);
      @(negedge clk_i);
      check("sweep_y_q",     y8_q,   sweep_exp[c]);
      check("sweep_sel_q",   sel8_q, c[1:0]);
      check("sweep_sel_chg", chg8,   1'b1);
    end

    // Hold 01 for three clocks, then switch to 10.
    s0 = 1'b0; s1 = 1'b1;
    @(negedge clk_i);
    check("hold_first_chg", chg8, 1'b1);
    @(negedge clk_i);
    check("hold_second_chg", chg8, 1'b0);
    @(negedge clk_i);
    check("hold_third_chg", chg8, 1'b0);
    check("hold_sel_q", sel8_q, 2'b01);
    s0 = 1'b1; s1 = 1'b0;
    @(negedge clk_i);
    check("switch_chg",   chg8,   1'b1);
    check("switch_sel_q", sel8_q, 2'b10);
    check("switch1_chg",  chg1,   1'b1);
    @(negedge clk_i);
    check("switch_chg_drop", chg8, 1'b0);

    // Asynchronous reset between edges while y_q holds 8'h88.
    s0 = 1'b1; s1 = 1'b1;
    @(negedge clk_i);
    check("pre_rst_y_q", y8_q, 8'h88);
    check("pre_rst_chg", chg8, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_y_q",   y8_q,   8'h00);
    check("async_rst_sel_q", sel8_q, 2'b00);
    check("async_rst_chg",   chg8,   1'b0);
    check("async_rst_y",     y8,     8'h88);
    @(negedge clk_i);
    check("held_rst_y_q", y8_q, 8'h00);

`ifdef MUX4X1_GATE_PARITY_EN
    x0 = 8'h07; s0 = 1'b0; s1 = 1'b0;
    rst_ni = 1'b1;
    #1;
    check("par_o",     par8_o, 1'b1);
    check("par_q_pre", par8_q, 1'b0);
    @(negedge clk_i);
    check("par_q",     par8_q, 1'b1);
    x0 = 8'h03;
    #1;
    check("par_o_even", par8_o, 1'b0);
    check("par1_o",     par1_o, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
